// File: rtl/dcache_port_responder.sv
// Data-cache port responder: answers the grant / tag / rvalid handshake of one
// LSU request port from a flat 64-bit-word SRAM, one request outstanding at a time.
`timescale 1ns/1ps

package dcache_port_pkg;
  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int DCACHE_TAG_WIDTH   = 44;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;
endpackage

module dcache_port_responder
  import dcache_port_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  dcache_req_i_t req_i,
  output dcache_req_o_t resp_o,
  input  logic          stall_i,
  output logic          addr_err_o
);

  localparam int          AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [63:0] SPAN     = 64'(MEM_WORDS) << 3;
  localparam logic [3:0]  LAT_LOAD = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, TAG, LAT} state_e;

  state_e                        state_q, state_d;
  logic [3:0]                    cnt_q, cnt_d;
  logic [DCACHE_INDEX_WIDTH-1:0] index_q;
  logic [63:0]                   word_q;
  logic [63:0]                   mem [MEM_WORDS];

  logic [DCACHE_INDEX_WIDTH-1:0] dec_index;
  logic [63:0]                   byte_addr;
  logic [63:0]                   offset;
  logic                          in_range;
  logic [AW-1:0]                 word_idx;

  logic gnt;
  logic rvalid;
  logic wr_en;
  logic tag_acc;
  logic addr_err;
  logic capture;

  // Writes use the live index; the tag phase of a read uses the index captured at grant.
  assign dec_index = (state_q == IDLE) ? req_i.address_index : index_q;
  assign byte_addr = 64'({req_i.address_tag, dec_index});
  assign offset    = byte_addr - BASE_ADDR;
  assign in_range  = (byte_addr >= BASE_ADDR) && (offset < SPAN);
  assign word_idx  = offset[3 +: AW];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt      = 1'b0;
    rvalid   = 1'b0;
    wr_en    = 1'b0;
    tag_acc  = 1'b0;
    addr_err = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt = req_i.data_req & ~stall_i;
        if (gnt) begin
          if (req_i.data_we) begin
            wr_en    = in_range;
            addr_err = ~in_range;
          end else begin
            capture = 1'b1;
            state_d = TAG;
          end
        end
      end
      TAG: begin
        if (req_i.kill_req) begin
          state_d = IDLE;
        end else if (req_i.tag_valid) begin
          tag_acc  = 1'b1;
          addr_err = ~in_range;
          cnt_d    = LAT_LOAD;
          state_d  = LAT;
        end
      end
      LAT: begin
        if (req_i.kill_req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          rvalid  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      index_q <= '0;
      word_q  <= 64'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) index_q <= req_i.address_index;
      if (tag_acc) word_q <= in_range ? mem[word_idx] : 64'h0;
    end
  end

  // SRAM contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (req_i.data_be[b]) mem[word_idx][8*b +: 8] <= req_i.data_wdata[8*b +: 8];
      end
    end
  end

  assign resp_o.data_gnt    = gnt;
  assign resp_o.data_rvalid = rvalid;
  assign resp_o.data_rdata  = rvalid ? word_q : 64'h0;
  assign addr_err_o         = addr_err;

  logic unused_bits;
  assign unused_bits = ^{req_i.data_size, offset[2:0], offset[63:AW+3]};

endmodule

// File: tb/tb_dcache_port_responder.sv
// Bench for dcache_port_responder: two instances (latency 1 at base 0, latency 4 at a
// high base) driven by a vector table, directed corner sequences and random traffic.
`timescale 1ns/1ps

module tb_dcache_port_responder;
  import dcache_port_pkg::*;

  localparam int          W     = 64;
  localparam logic [63:0] BASE0 = 64'h0;
  localparam logic [63:0] BASE1 = 64'h0000_0040_0000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  dcache_req_i_t req   [2];
  logic          stall [2];
  dcache_req_o_t resp  [2];
  logic          err   [2];

  int vectors     = 0;
  int miscompares = 0;
  logic [63:0] model [2][W];

  always #5 clk = ~clk;

  dcache_port_responder #(.MEM_WORDS(W), .BASE_ADDR(BASE0), .RD_LATENCY(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .resp_o(resp[0]),
    .stall_i(stall[0]), .addr_err_o(err[0]));

  dcache_port_responder #(.MEM_WORDS(W), .BASE_ADDR(BASE1), .RD_LATENCY(4)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .resp_o(resp[1]),
    .stall_i(stall[1]), .addr_err_o(err[1]));

  typedef struct {
    logic rq, we; logic [7:0] be; logic [63:0] wd; logic [55:0] ia, ta;
    logic tv, kill, st; logic eg, erv; logic [63:0] erd; logic eerr;
  } vec_t;
  vec_t tbl [$];

  function automatic int lat_of(int p);
    return (p == 0) ? 1 : 4;
  endfunction

  function automatic logic [63:0] base_of(int p);
    return (p == 0) ? BASE0 : BASE1;
  endfunction

  function automatic logic [63:0] init_val(int p, int i);
    return {8'hC0, 8'(p), 16'(i), 32'h600D_0000 + 32'(i) * 32'h11};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic cmp(string name, int p, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s port%0d: got %h, expected %h", name, p, act, exp);
    end
  endtask

  task automatic apply_stimulus(int p, logic rq, logic we, logic [7:0] be, logic [63:0] wd,
                                logic [55:0] ia, logic [55:0] ta, logic tv, logic kill,
                                logic st);
    req[p].data_req      = rq;
    req[p].data_we       = we;
    req[p].data_be       = be;
    req[p].data_wdata    = wd;
    req[p].address_index = ia[11:0];
    req[p].address_tag   = ta[55:12];
    req[p].data_size     = 2'($urandom);
    req[p].tag_valid     = tv;
    req[p].kill_req      = kill;
    stall[p]             = st;
  endtask

  task automatic check_output(int p, string name, logic eg, logic erv, logic [63:0] erd,
                              logic eerr);
    cmp({name, ".gnt"},    p, 64'(resp[p].data_gnt),    64'(eg));
    cmp({name, ".rvalid"}, p, 64'(resp[p].data_rvalid), 64'(erv));
    cmp({name, ".rdata"},  p, resp[p].data_rdata,       erd);
    cmp({name, ".err"},    p, 64'(err[p]),              64'(eerr));
  endtask

  task automatic step_check(int p, string name, logic eg, logic erv, logic [63:0] erd,
                            logic eerr);
    @(negedge clk);
    check_output(p, name, eg, erv, erd, eerr);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_port(int p);
    apply_stimulus(p, 0, 0, 8'h0, 64'h0, 56'h0, 56'h0, 0, 0, 0);
  endtask

  task automatic add_vec(logic rq, logic we, logic [7:0] be, logic [63:0] wd, logic [55:0] ia,
                         logic [55:0] ta, logic tv, logic kill, logic st, logic eg, logic erv,
                         logic [63:0] erd, logic eerr);
    vec_t v;
    v = '{rq, we, be, wd, ia, ta, tv, kill, st, eg, erv, erd, eerr};
    tbl.push_back(v);
  endtask

  task automatic pick_addr(int p, output logic [55:0] a, output logic inr, output int w);
    logic [63:0] b, a64;
    int r;
    b = base_of(p);
    r = $urandom_range(0, 9);
    if (r == 0)      a64 = b + 64'(W) * 8 + 64'($urandom_range(0, 31));
    else if (r == 1) a64 = b - 64'($urandom_range(1, 16));
    else             a64 = b + 64'($urandom_range(0, W * 8 - 1));
    a   = a64[55:0];
    a64 = 64'(a);
    inr = (a64 >= b) && (a64 < b + 64'(W) * 8);
    w   = inr ? int'((a64 - b) >> 3) : 0;
  endtask

  task automatic rand_write(int p);
    logic [55:0] a; logic inr; int w; logic [7:0] be; logic [63:0] d;
    pick_addr(p, a, inr, w);
    be = 8'($urandom);
    d  = rand64();
    repeat ($urandom_range(0, 2)) begin
      apply_stimulus(p, 1, 1, be, d, a, a, 0, 0, 1);
      step_check(p, "wr_stall", 0, 0, 64'h0, 0);
    end
    apply_stimulus(p, 1, 1, be, d, a, a, 0, 0, 0);
    step_check(p, "wr_gnt", 1, 0, 64'h0, !inr);
    if (inr) for (int b = 0; b < 8; b++) if (be[b]) model[p][w][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic rand_read(int p);
    logic [55:0] a; logic inr; int w; int mode, kk, lat; logic kill_now;
    logic [63:0] exp_d;
    pick_addr(p, a, inr, w);
    lat   = lat_of(p);
    exp_d = inr ? model[p][w] : 64'h0;
    repeat ($urandom_range(0, 2)) begin
      apply_stimulus(p, 1, 0, 8'($urandom), rand64(), a, 56'(rand64()), 0, 0, 1);
      step_check(p, "rd_stall", 0, 0, 64'h0, 0);
    end
    apply_stimulus(p, 1, 0, 8'($urandom), rand64(), a, 56'(rand64()), 0, 0, 0);
    step_check(p, "rd_gnt", 1, 0, 64'h0, 0);
    mode = $urandom_range(0, 7);
    kk   = $urandom_range(1, lat);
    repeat ($urandom_range(0, 2)) begin
      apply_stimulus(p, 1'($urandom), 0, 8'h0, 64'h0, 56'(rand64()), 56'(rand64()), 0, 0,
                     1'($urandom));
      step_check(p, "rd_wait", 0, 0, 64'h0, 0);
    end
    apply_stimulus(p, 1'($urandom), 0, 8'h0, 64'h0, 56'(rand64()), a,
                   (mode == 0) ? 1'($urandom) : 1'b1, mode == 0, 0);
    step_check(p, "rd_tag", 0, 0, 64'h0, (mode != 0) && !inr);
    if (mode == 0) return;
    for (int k = 1; k <= lat; k++) begin
      kill_now = (mode == 1) && (k == kk);
      apply_stimulus(p, 1'($urandom), 0, 8'h0, 64'h0, 56'(rand64()), 56'(rand64()),
                     1'($urandom), kill_now, 0);
      if (kill_now) begin
        step_check(p, "rd_kill", 0, 0, 64'h0, 0);
        return;
      end
      step_check(p, "rd_lat", 0, k == lat, (k == lat) ? exp_d : 64'h0, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected run to complete");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    logic [55:0] a5, g, gt, a;
    logic [63:0] d1, d2;

    idle_port(0);
    idle_port(1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_output(0, "reset", 0, 0, 64'h0, 0);
    check_output(1, "reset", 0, 0, 64'h0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill both memories with back-to-back full-word writes.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < W; i++) begin
        a = 56'(base_of(p) + 64'(i) * 8);
        apply_stimulus(p, 1, 1, 8'hFF, init_val(p, i), a, a, 0, 0, 0);
        step_check(p, "init_wr", 1, 0, 64'h0, 0);
        model[p][i] = init_val(p, i);
      end
      idle_port(p);
    end

    a5 = 56'h28; g = 56'h38; gt = 56'h77_7000;
    d1 = 64'h0123_4567_89AB_CDEF;
    d2 = 64'h0123_4567_FFFF_FFFF;
    add_vec(0, 0, 8'h00, 64'h0, 56'h0, 56'h0, 0, 0, 0,  0, 0, 64'h0, 0);
    add_vec(1, 1, 8'hFF, d1,    a5,    a5,    0, 0, 0,  1, 0, 64'h0, 0);
    add_vec(1, 0, 8'h00, 64'h0, a5,    gt,    0, 0, 0,  1, 0, 64'h0, 0);
    add_vec(0, 0, 8'h00, 64'h0, g,     a5,    1, 0, 0,  0, 0, 64'h0, 0);
    add_vec(0, 0, 8'h00, 64'h0, 56'h0, 56'h0, 0, 0, 0,  0, 1, d1,    0);
    add_vec(0, 0, 8'h00, 64'h0, 56'h0, 56'h0, 0, 0, 0,  0, 0, 64'h0, 0);
    add_vec(1, 1, 8'h0F, '1,    a5,    a5,    0, 0, 0,  1, 0, 64'h0, 0);
    add_vec(1, 0, 8'h00, 64'h0, a5,    gt,    0, 0, 0,  1, 0, 64'h0, 0);
    add_vec(0, 0, 8'h00, 64'h0, g,     a5,    1, 0, 0,  0, 0, 64'h0, 0);
    add_vec(0, 0, 8'h00, 64'h0, 56'h0, 56'h0, 0, 0, 0,  0, 1, d2,    0);
    add_vec(1, 0, 8'h00, 64'h0, a5,    gt,    0, 0, 0,  1, 0, 64'h0, 0);
    add_vec(1, 0, 8'h00, 64'h0, g,     a5,    1, 1, 0,  0, 0, 64'h0, 0);
    add_vec(1, 0, 8'h00, 64'h0, a5,    gt,    0, 0, 0,  1, 0, 64'h0, 0);
    add_vec(0, 0, 8'h00, 64'h0, g,     a5,    1, 0, 0,  0, 0, 64'h0, 0);
    add_vec(0, 0, 8'h00, 64'h0, 56'h0, 56'h0, 0, 0, 0,  0, 1, d2,    0);
    add_vec(1, 0, 8'h00, 64'h0, 56'h200, gt,  0, 0, 0,  1, 0, 64'h0, 0);
    add_vec(0, 0, 8'h00, 64'h0, g,     56'h200, 1, 0, 0, 0, 0, 64'h0, 1);
    add_vec(0, 0, 8'h00, 64'h0, 56'h0, 56'h0, 0, 0, 0,  0, 1, 64'h0, 0);
    add_vec(1, 1, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 56'h200, 56'h200, 0, 0, 0, 1, 0, 64'h0, 1);
    add_vec(1, 0, 8'h00, 64'h0, 56'h0, gt,    0, 0, 0,  1, 0, 64'h0, 0);
    add_vec(0, 0, 8'h00, 64'h0, g,     56'h0, 1, 0, 0,  0, 0, 64'h0, 0);
    add_vec(0, 0, 8'h00, 64'h0, 56'h0, 56'h0, 0, 0, 0,  0, 1, init_val(0, 0), 0);
    add_vec(1, 0, 8'h00, 64'h0, a5,    gt,    0, 1, 0,  1, 0, 64'h0, 0);
    add_vec(0, 0, 8'h00, 64'h0, g,     a5,    1, 0, 0,  0, 0, 64'h0, 0);
    add_vec(0, 0, 8'h00, 64'h0, 56'h0, 56'h0, 0, 0, 0,  0, 1, d2,    0);
    for (int i = 0; i < 3; i++)
      add_vec(1, 0, 8'h00, 64'h0, 56'h30, gt, 0, 0, 1,  0, 0, 64'h0, 0);
    add_vec(1, 0, 8'h00, 64'h0, 56'h30, gt,   0, 0, 0,  1, 0, 64'h0, 0);
    add_vec(0, 0, 8'h00, 64'h0, g,     56'h30, 1, 0, 0, 0, 0, 64'h0, 0);
    add_vec(0, 0, 8'h00, 64'h0, 56'h0, 56'h0, 0, 0, 0,  0, 1, init_val(0, 6), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(0, tbl[i].rq, tbl[i].we, tbl[i].be, tbl[i].wd, tbl[i].ia, tbl[i].ta,
                     tbl[i].tv, tbl[i].kill, tbl[i].st);
      step_check(0, $sformatf("tbl%0d", i), tbl[i].eg, tbl[i].erv, tbl[i].erd, tbl[i].eerr);
    end
    model[0][5] = d2;
    idle_port(0);

    // Latency-4 port: three stalled cycles, then the tag arrives two cycles late.
    a = 56'(BASE1 + 64'd72);
    repeat (3) begin
      apply_stimulus(1, 1, 0, 8'h0, 64'h0, a, gt, 0, 0, 1);
      step_check(1, "stall3", 0, 0, 64'h0, 0);
    end
    apply_stimulus(1, 1, 0, 8'h0, 64'h0, a, gt, 0, 0, 0);
    step_check(1, "stall_gnt", 1, 0, 64'h0, 0);
    repeat (2) begin
      idle_port(1);
      step_check(1, "tag_delay", 0, 0, 64'h0, 0);
    end
    apply_stimulus(1, 0, 0, 8'h0, 64'h0, g, a, 1, 0, 0);
    step_check(1, "late_tag", 0, 0, 64'h0, 0);
    for (int k = 1; k <= 4; k++) begin
      idle_port(1);
      step_check(1, "lat4", 0, k == 4, (k == 4) ? model[1][9] : 64'h0, 0);
    end

    // Reset lands in the very cycle the read would have completed.
    a = 56'(BASE1 + 64'd24);
    apply_stimulus(1, 1, 0, 8'h0, 64'h0, a, gt, 0, 0, 0);
    step_check(1, "rst_gnt", 1, 0, 64'h0, 0);
    apply_stimulus(1, 0, 0, 8'h0, 64'h0, g, a, 1, 0, 0);
    step_check(1, "rst_tag", 0, 0, 64'h0, 0);
    repeat (3) begin
      idle_port(1);
      step_check(1, "rst_lat", 0, 0, 64'h0, 0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_output(1, "rst_mid", 0, 0, 64'h0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) step_check(1, "post_rst", 0, 0, 64'h0, 0);
    apply_stimulus(1, 1, 0, 8'h0, 64'h0, a, gt, 0, 0, 0);
    step_check(1, "rerd_gnt", 1, 0, 64'h0, 0);
    apply_stimulus(1, 0, 0, 8'h0, 64'h0, g, a, 1, 0, 0);
    step_check(1, "rerd_tag", 0, 0, 64'h0, 0);
    for (int k = 1; k <= 4; k++) begin
      idle_port(1);
      step_check(1, "rerd_lat", 0, k == 4, (k == 4) ? model[1][3] : 64'h0, 0);
    end

    for (int p = 0; p < 2; p++) begin
      repeat (150) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: rand_write(p);
          4: begin
            apply_stimulus(p, 0, 0, 8'h0, 64'h0, 56'(rand64()), 56'(rand64()), 1'($urandom),
                           1'b1, 1'($urandom));
            step_check(p, "idle_kill", 0, 0, 64'h0, 0);
          end
          default: rand_read(p);
        endcase
      end
      idle_port(p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dcache_port_responder.md
# dcache_port_responder

Cache-side responder for one ex_stage data-cache request port (`dcache_req_i_t` in, `dcache_req_o_t` out), backed by a flat 64-bit-word SRAM. Provides the grant / tag-phase / read-valid handshake the load unit, store unit and PTW expect, so the LSU can run standalone or against a deterministic memory in unit benches. One request outstanding at a time; grant can be throttled externally.

## Interface
- `MEM_WORDS`, 1024: SRAM depth in 64-bit words (power of two).
- `BASE_ADDR`, 64'h0: byte address of word 0 (8-byte aligned).
- `RD_LATENCY`, 1: cycles from accepted tag to `data_rvalid` (legal 1..15).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock; asynchronous, active-low.
- `req_i`  in  `dcache_req_i_t`  port request: `address_index`[DCACHE_INDEX_WIDTH], `address_tag`[DCACHE_TAG_WIDTH], `data_wdata`[64], `data_req`, `data_we`, `data_be`[8], `data_size`[2], `kill_req`, `tag_valid`.
- `resp_o`  out  `dcache_req_o_t`  `data_gnt`, `data_rvalid`, `data_rdata`[64].
- `stall_i`  in  1  suppress grant while high.
- `addr_err_o`  out  1  one-cycle pulse: access outside [BASE_ADDR, BASE_ADDR+8*MEM_WORDS).

## Operation
- Byte address = {address_tag, address_index}; word = (addr − BASE_ADDR) >> 3. Bits [2:0] ignored; `data_be` authoritative for writes, `data_size` ignored.
- FSM states: IDLE, TAG, LAT.
- IDLE: `data_gnt` = `data_req` & !`stall_i` (combinational). Grant only in IDLE.
  - Granted write: full address (tag+index) valid in grant cycle; bytes with `data_be[i]`=1 written at clock edge; no `data_rvalid`; stay IDLE.
  - Granted read: capture `address_index` -> TAG.
- TAG: wait for tag phase.
  - `kill_req`=1 (with or without `tag_valid`) -> IDLE, no rvalid (kill wins).
  - `tag_valid`=1 -> form address from captured index + current tag, read SRAM word, load latency counter with RD_LATENCY−1 -> LAT.
- LAT: counter decrements each cycle; `kill_req` -> IDLE, no rvalid. When counter is 0: `data_rvalid`=1, `data_rdata`=word for one cycle -> IDLE.
- `data_rdata` = 0 whenever `data_rvalid`=0.
- Out-of-range: writes dropped, reads return 0 with normal rvalid timing; `addr_err_o` pulses in the write grant cycle or read tag-accept cycle.
- SRAM contents not reset; state registers are.

## Timing
- Reset: state IDLE, counter 0, `data_gnt`/`data_rvalid`/`addr_err_o` = 0 (`data_gnt` is 0 only while `data_req`=0 or `stall_i`=1), `data_rdata` 0. Reset mid-transaction abandons it; no rvalid afterwards.
- Read: req/gnt cycle T, earliest tag T+1, rvalid T+1+RD_LATENCY. Tag may arrive any number of cycles later.
- Write: gnt cycle T; read of same word granted at T+1 returns new data.
- Next grant earliest: the cycle after rvalid, kill or write grant (write grants may be back-to-back).
- `stall_i` sampled only in IDLE; a stalled request keeps `data_req` high and is granted the first cycle `stall_i`=0.
- `kill_req` in IDLE ignored.

## Test plan
- Write 64'h0123_4567_89AB_CDEF, be=8'hFF, word 5; read word 5, tag at T+1, RD_LATENCY=1 -> gnt at T, rvalid at T+2 with same data, rdata 0 other cycles.
- Partial write be=8'h0F data 64'hFFFF_FFFF_FFFF_FFFF over word 5 -> read returns 64'h0123_4567_FFFF_FFFF.
- Read granted, `kill_req` with `tag_valid` in TAG -> no rvalid; new req granted next cycle, returns correct data.
- `stall_i` high 3 cycles with `data_req` high -> gnt 0 for 3 cycles, asserted cycle 4; RD_LATENCY=4, tag delayed 2 cycles -> rvalid exactly 4 cycles after tag.
- Read at BASE_ADDR+8*MEM_WORDS -> `addr_err_o` pulse at tag accept, rvalid with data 0; write there leaves all words unchanged.
- Assert `rst_ni` low while in LAT -> outputs 0 immediately, no rvalid after release; next read completes normally.
